alu_slice_seq_ctrl: RTL and testbench
=====================================

Name: alu_slice_seq_ctrl

Overview:
- Multi-cycle controller that sequences one external 4-bit carry-lookahead adder slice to perform a WIDTH-bit add or subtract, one nibble per cycle, LSB first.
- Sits between the ALU issue logic and a single shared 4-bit CLA slice. Trades latency for area when a full-width adder is not instantiated.
- Provides valid/ready handshakes on both input and output, two's-complement overflow detection, and optional saturation.

Parameters:
- SLICES, 4, number of 4-bit slices per operation; WIDTH = 4*SLICES (default 16).

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  operation request
- in_ready  output  1  controller can accept a request
- op_sub  input  1  1 = a - b, 0 = a + b
- sat_en  input  1  1 = saturate result on signed overflow
- a  input  WIDTH  operand A, two's complement
- b  input  WIDTH  operand B, two's complement
- out_valid  output  1  result available
- out_ready  input  1  consumer accepts result
- result  output  WIDTH  sum/difference, possibly saturated
- ovfl  output  1  signed overflow of the full-width operation
- cout  output  1  carry out of MSB (for subtract: 1 = no borrow)
- slice_a  output  4  nibble of A driven to the CLA slice
- slice_b  output  4  nibble of B (inverted for subtract) driven to the slice
- slice_cin  output  1  carry into the slice
- slice_sum  input  4  slice sum, combinational
- slice_cout  input  1  slice carry out, combinational
- slice_ovfl  input  1  slice signed overflow, combinational; used only on the top slice

Behaviour:
- States: IDLE, RUN, DONE. Reset forces IDLE.
- Reset values: in_ready=1, out_valid=0, result=0, ovfl=0, cout=0, slice_a=0, slice_b=0, slice_cin=0. All internal registers (operands, index, carry, flags) are cleared.
- in_ready = (state==IDLE). It is combinational from the state register.
- IDLE, when in_valid and in_ready:
  - latch opA<=a, opB<=(op_sub ? ~b : b), carry<=op_sub, sat<=sat_en, idx<=0;
  - go to RUN.
  - in_valid is ignored in all other states.
- RUN, each cycle:
  - slice_a = opA[4*idx+3:4*idx], slice_b = opB nibble idx, slice_cin = carry;
  - on the clock edge, capture slice_sum into result nibble idx, carry<=slice_cout, idx<=idx+1.
- RUN, on the cycle where idx==SLICES-1:
  - also capture ovfl<=slice_ovfl and cout<=slice_cout;
  - go to DONE.
- Saturation is applied at the RUN→DONE edge when sat and slice_ovfl are both 1. result becomes opA[WIDTH-1] ? {1'b1,{WIDTH-1{1'b0}}} : {1'b0,{WIDTH-1{1'b1}}}. ovfl is still reported as 1.
- Slice outputs are 0 in IDLE and DONE.
- DONE:
  - out_valid=1; result, ovfl and cout are held stable;
  - when out_ready is high, go to IDLE. out_valid drops the following cycle.
- A new request cannot be accepted in the same cycle the result is consumed, because in_ready=0 in DONE.
- Latency: a request accepted at edge 0 gives RUN cycles 1..SLICES. out_valid is high from cycle SLICES+1. Minimum initiation interval is SLICES+2 cycles.
- result, ovfl and cout retain their values through IDLE until overwritten by the next operation. The first nibble write of a new operation is at the first RUN edge.
- Operand inputs may change freely after acceptance; only latched copies are used.
- rst_n asserted in any state, including mid-RUN or while DONE with out_ready low:
  - returns immediately to reset values;
  - the in-flight operation is discarded and no out_valid pulse is produced.
- idx width is clog2(SLICES), minimum 1 bit. No idx wrap is reachable because RUN exits at SLICES-1.

Test Plan:
- Add 0x1234+0x4321, sat_en=0, out_ready=1 → out_valid exactly 5 cycles after acceptance; result=0x5555, ovfl=0, cout=0; slice_cin=0 on every RUN cycle.
- Add 0x7FFF+0x0001 → with sat_en=0: result=0x8000, ovfl=1, cout=0. Repeat with sat_en=1 → result=0x7FFF, ovfl=1.
- Subtract 0x0005-0x0007 → result=0xFFFE, ovfl=0, cout=0. Also check first RUN cycle slice_b=0x8 (~0x7 nibble) and slice_cin=1.
- Subtract 0x8000-0x0001, sat_en=1 → result=0x8000, ovfl=1, cout=1.
- Backpressure: hold out_ready=0 for 3 cycles in DONE with in_valid=1 → result stable, in_ready=0, no new operation accepted. Raise out_ready → IDLE next cycle, then the pending request is accepted.
- Assert rst_n=0 during the 2nd RUN cycle → all outputs at reset values immediately, in_ready=1 after release, no out_valid. Next add 0xFFFF+0x0001 → result=0x0000, cout=1, ovfl=0.

Source files
------------

// File: rtl/alu_slice_seq_ctrl.sv
// alu_slice_seq_ctrl
//   Sequences one shared external 4-bit CLA slice through a WIDTH-bit add or
//   subtract, one nibble per cycle, LSB first. Subtraction feeds ~b with a
//   carry-in of 1. Signed overflow is taken from the top slice, with optional
//   saturation of the result.
//
// Ports
//   clk, rst_n            clock (rising edge), asynchronous active-low reset
//   in_valid / in_ready   request handshake; in_ready is high only in IDLE
//   op_sub, sat_en        1 = a - b / 1 = saturate on signed overflow
//   a, b                  WIDTH-bit two's-complement operands, latched on accept
//   out_valid / out_ready result handshake; out_valid is high only in DONE
//   result, ovfl, cout    registered result, signed overflow, MSB carry out
//   slice_a/_b/_cin       nibble operands and carry driven to the slice (0 unless RUN)
//   slice_sum/_cout/_ovfl combinational slice results
module alu_slice_seq_ctrl #(
    parameter  int unsigned SLICES = 4,
    localparam int unsigned WIDTH  = 4 * SLICES
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             op_sub,
    input  logic             sat_en,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             ovfl,
    output logic             cout,
    output logic [3:0]       slice_a,
    output logic [3:0]       slice_b,
    output logic             slice_cin,
    input  logic [3:0]       slice_sum,
    input  logic             slice_cout,
    input  logic             slice_ovfl
);

    localparam int unsigned IDXW = (SLICES > 1) ? $clog2(SLICES) : 1;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t state_q, state_d;

    logic [WIDTH-1:0] opa_q, opa_d;
    logic [WIDTH-1:0] opb_q, opb_d;
    logic             carry_q, carry_d;
    logic             sat_q, sat_d;
    logic [IDXW-1:0]  idx_q, idx_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             ovfl_q, ovfl_d;
    logic             cout_q, cout_d;

    logic             last_slice;

    assign last_slice = (idx_q == IDXW'(SLICES - 1));

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (in_valid)   state_d = RUN;
            RUN:     if (last_slice) state_d = DONE;
            DONE:    if (out_ready)  state_d = IDLE;
            default:                 state_d = IDLE;
        endcase
    end

    // Outputs decoded from state; slice nibble chosen by a constant-index
    // loop so every part-select stays static.
    always_comb begin
        in_ready  = (state_q == IDLE);
        out_valid = (state_q == DONE);
        slice_a   = '0;
        slice_b   = '0;
        slice_cin = 1'b0;
        if (state_q == RUN) begin
            slice_cin = carry_q;
            for (int unsigned i = 0; i < SLICES; i++) begin
                if (idx_q == IDXW'(i)) begin
                    slice_a = opa_q[4*i +: 4];
                    slice_b = opb_q[4*i +: 4];
                end
            end
        end
    end

    // Datapath next-state
    always_comb begin
        opa_d    = opa_q;
        opb_d    = opb_q;
        carry_d  = carry_q;
        sat_d    = sat_q;
        idx_d    = idx_q;
        result_d = result_q;
        ovfl_d   = ovfl_q;
        cout_d   = cout_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    opa_d   = a;
                    opb_d   = op_sub ? ~b : b;
                    carry_d = op_sub;
                    sat_d   = sat_en;
                    idx_d   = '0;
                end
            end
            RUN: begin
                for (int unsigned i = 0; i < SLICES; i++) begin
                    if (idx_q == IDXW'(i)) begin
                        result_d[4*i +: 4] = slice_sum;
                    end
                end
                carry_d = slice_cout;
                idx_d   = idx_q + 1'b1;
                if (last_slice) begin
                    ovfl_d = slice_ovfl;
                    cout_d = slice_cout;
                    // Overflow direction follows the sign of A: a negative A
                    // can only overflow downward, a positive A only upward.
                    if (sat_q && slice_ovfl) begin
                        result_d = opa_q[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                                                  : {1'b0, {(WIDTH-1){1'b1}}};
                    end
                end
            end
            default: ;
        endcase
    end

    // Datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            opa_q    <= '0;
            opb_q    <= '0;
            carry_q  <= 1'b0;
            sat_q    <= 1'b0;
            idx_q    <= '0;
            result_q <= '0;
            ovfl_q   <= 1'b0;
            cout_q   <= 1'b0;
        end else begin
            opa_q    <= opa_d;
            opb_q    <= opb_d;
            carry_q  <= carry_d;
            sat_q    <= sat_d;
            idx_q    <= idx_d;
            result_q <= result_d;
            ovfl_q   <= ovfl_d;
            cout_q   <= cout_d;
        end
    end

    assign result = result_q;
    assign ovfl   = ovfl_q;
    assign cout   = cout_q;

endmodule

// File: tb/tb_alu_slice_seq_ctrl.sv
// Bench for alu_slice_seq_ctrl: emulates the 4-bit CLA slice, applies directed
// and random add/subtract operations and compares against a full-width
// signed/unsigned arithmetic reference.
module tb_alu_slice_seq_ctrl;

    localparam int unsigned SLICES = 4;
    localparam int unsigned W      = 16;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic          op_sub;
    logic          sat_en;
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  result;
    logic          ovfl;
    logic          cout;
    logic [3:0]    slice_a;
    logic [3:0]    slice_b;
    logic          slice_cin;
    logic [3:0]    slice_sum;
    logic          slice_cout;
    logic          slice_ovfl;

    int unsigned   vectors     = 0;
    int unsigned   miscompares = 0;

    always #5 clk = ~clk;

    alu_slice_seq_ctrl #(.SLICES(SLICES)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .op_sub     (op_sub),
        .sat_en     (sat_en),
        .a          (a),
        .b          (b),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .result     (result),
        .ovfl       (ovfl),
        .cout       (cout),
        .slice_a    (slice_a),
        .slice_b    (slice_b),
        .slice_cin  (slice_cin),
        .slice_sum  (slice_sum),
        .slice_cout (slice_cout),
        .slice_ovfl (slice_ovfl)
    );

    // Combinational 4-bit adder slice
    logic [4:0] sl_full;
    assign sl_full    = {1'b0, slice_a} + {1'b0, slice_b} + {4'b0000, slice_cin};
    assign slice_sum  = sl_full[3:0];
    assign slice_cout = sl_full[4];
    assign slice_ovfl = (slice_a[3] == slice_b[3]) && (slice_sum[3] != slice_a[3]);

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference: exact signed arithmetic, unsigned carry/borrow.
    function automatic void model(input logic [15:0] ma, input logic [15:0] mb,
                                  input logic msub, input logic msat,
                                  output logic [15:0] r, output logic ov, output logic co);
        int sa, sb, ex;
        sa = $signed(ma);
        sb = $signed(mb);
        ex = msub ? (sa - sb) : (sa + sb);
        ov = (ex > 32767) || (ex < -32768);
        co = msub ? (ma >= mb) : ((32'(ma) + 32'(mb)) > 32'd65535);
        if (msat && ov) r = (ex < 0) ? 16'h8000 : 16'h7FFF;
        else            r = ex[15:0];
    endfunction

    // Carry into nibble i of a + (b or ~b) + sub
    function automatic logic exp_cin(input logic [15:0] ma, input logic [15:0] mb,
                                     input logic msub, input int unsigned i);
        int unsigned mask, s, ua, ub;
        ua   = 32'(ma);
        ub   = msub ? 32'(~mb) : 32'(mb);
        mask = (32'd1 << (4 * i)) - 32'd1;
        s    = (ua & mask) + (ub & mask) + 32'(msub);
        return ((s >> (4 * i)) & 32'd1) != 0;
    endfunction

    // Call at #1 after an edge with the DUT in IDLE.
    task automatic do_op(input logic [15:0] ta, input logic [15:0] tb2,
                         input logic ts, input logic tsat,
                         input int unsigned hold, input logic pend);
        logic [15:0] er, bb;
        logic        eo, ec;
        int unsigned n;
        model(ta, tb2, ts, tsat, er, eo, ec);
        bb       = ts ? ~tb2 : tb2;
        a        = ta;
        b        = tb2;
        op_sub   = ts;
        sat_en   = tsat;
        in_valid = 1'b1;
        check("in_ready_idle", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        a        = 16'($urandom);
        b        = 16'($urandom);
        op_sub   = 1'($urandom);
        sat_en   = 1'($urandom);
        n = 0;
        while (out_valid !== 1'b1 && n < SLICES + 4) begin
            out_ready = 1'($urandom);
            if (n < SLICES) begin
                check("slice_a",   32'(slice_a),   32'(ta[4*n +: 4]));
                check("slice_b",   32'(slice_b),   32'(bb[4*n +: 4]));
                check("slice_cin", 32'(slice_cin), 32'(exp_cin(ta, tb2, ts, n)));
                check("in_ready_run", 32'(in_ready), 32'd0);
            end
            @(posedge clk); #1;
            n++;
        end
        out_ready = 1'b0;
        check("latency",  n,            SLICES);
        check("result",   32'(result),  32'(er));
        check("ovfl",     32'(ovfl),    32'(eo));
        check("cout",     32'(cout),    32'(ec));
        check("in_ready_done", 32'(in_ready), 32'd0);
        check("slice_idle", {23'd0, slice_a, slice_b, slice_cin}, 32'd0);
        in_valid = pend;
        for (int unsigned h = 0; h < hold; h++) begin
            a = 16'($urandom);
            b = 16'($urandom);
            @(posedge clk); #1;
            check("hold_valid",  32'(out_valid), 32'd1);
            check("hold_ready",  32'(in_ready),  32'd0);
            check("hold_result", 32'(result),    32'(er));
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("consumed_valid", 32'(out_valid), 32'd0);
        check("consumed_ready", 32'(in_ready),  32'd1);
        check("retain_result",  32'(result),    32'(er));
        check("retain_flags",   {30'd0, ovfl, cout}, {30'd0, eo, ec});
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        op_sub    = 1'b0;
        sat_en    = 1'b0;
        a         = '0;
        b         = '0;
        out_ready = 1'b0;
        #1;
        check("rst_in_ready",  32'(in_ready),  32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_outputs", {13'd0, result, ovfl, cout, 1'b0},  32'd0);
        check("rst_slice", {23'd0, slice_a, slice_b, slice_cin}, 32'd0);
        @(posedge clk);
        @(posedge clk); #1;
        rst_n = 1'b1;

        do_op(16'h1234, 16'h4321, 1'b0, 1'b0, 0, 1'b0);
        do_op(16'h7FFF, 16'h0001, 1'b0, 1'b0, 1, 1'b0);
        do_op(16'h7FFF, 16'h0001, 1'b0, 1'b1, 0, 1'b0);
        do_op(16'h0005, 16'h0007, 1'b1, 1'b0, 0, 1'b0);
        do_op(16'h8000, 16'h0001, 1'b1, 1'b1, 2, 1'b0);
        // Backpressure with a pending request held through DONE
        do_op(16'h0F0F, 16'h00F1, 1'b0, 1'b0, 3, 1'b1);
        do_op(16'h1111, 16'h2222, 1'b0, 1'b0, 0, 1'b0);

        for (int unsigned k = 0; k < 40; k++) begin
            logic [15:0] ra, rb;
            ra = 16'($urandom);
            rb = 16'($urandom);
            case ($urandom_range(0, 5))
                0: ra = 16'h7FFF;
                1: ra = 16'h8000;
                2: rb = 16'hFFFF;
                default: ;
            endcase
            do_op(ra, rb, 1'($urandom), 1'($urandom),
                  $urandom_range(0, 3), 1'($urandom));
            if (!in_valid) begin
                for (int unsigned g = 0; g < $urandom_range(0, 2); g++) begin
                    @(posedge clk); #1;
                    check("gap_ready", 32'(in_ready), 32'd1);
                end
            end
        end

        // Leave non-zero result/flags so the reset check is meaningful
        in_valid = 1'b0;
        do_op(16'h8000, 16'h0001, 1'b1, 1'b1, 0, 1'b0);

        // Reset during the second RUN cycle
        a        = 16'hABCD;
        b        = 16'h1357;
        op_sub   = 1'b0;
        sat_en   = 1'b0;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        check("midrun_rst_ready",  32'(in_ready),  32'd1);
        check("midrun_rst_valid",  32'(out_valid), 32'd0);
        check("midrun_rst_result", 32'(result),    32'd0);
        check("midrun_rst_flags",  {30'd0, ovfl, cout}, 32'd0);
        check("midrun_rst_slice",  {23'd0, slice_a, slice_b, slice_cin}, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int unsigned k = 0; k < 8; k++) begin
            @(posedge clk); #1;
            check("post_rst_valid", 32'(out_valid), 32'd0);
            check("post_rst_ready", 32'(in_ready),  32'd1);
        end
        do_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, 0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
